// File: rtl/bht_gshare_if.sv
// bht_gshare_if: prediction request/response and resolved-branch update bundle
// for the gshare branch history table.
//   pred_valid/pred_pc                         : prediction request (master -> table)
//   pred_out_valid/pred_taken/pred_index/pred_ghr : registered prediction result (table -> master)
//   upd_valid/upd_index/upd_ghr/upd_taken/upd_mispredict : resolved-branch update (master -> table)
interface bht_gshare_if #(
    parameter int INDEX_BITS = 12,
    parameter int GHR_BITS   = 8
);
    logic                  pred_valid;
    logic [31:0]           pred_pc;
    logic                  pred_out_valid;
    logic                  pred_taken;
    logic [INDEX_BITS-1:0] pred_index;
    logic [GHR_BITS-1:0]   pred_ghr;
    logic                  upd_valid;
    logic [INDEX_BITS-1:0] upd_index;
    logic [GHR_BITS-1:0]   upd_ghr;
    logic                  upd_taken;
    logic                  upd_mispredict;

    modport master (
        output pred_valid, pred_pc,
        output upd_valid, upd_index, upd_ghr, upd_taken, upd_mispredict,
        input  pred_out_valid, pred_taken, pred_index, pred_ghr
    );

    modport slave (
        input  pred_valid, pred_pc,
        input  upd_valid, upd_index, upd_ghr, upd_taken, upd_mispredict,
        output pred_out_valid, pred_taken, pred_index, pred_ghr
    );
endinterface

// File: rtl/bht_gshare.sv
// bht_gshare: gshare branch predictor. A table of 2^INDEX_BITS saturating
// counters is indexed by PC[INDEX_BITS+1:2] XOR the global history register.
// After reset the table is walked once (one entry per rdy cycle) to the
// weakly-not-taken value before predictions are accepted.
//   clk  : clock, all state updates on the rising edge
//   rst  : asynchronous active-low reset
//   rdy  : global enable, low freezes all state
//   busy : high while the table-clear sequence runs
//   bus  : prediction / update bundle (slave side)
module bht_gshare #(
    parameter int INDEX_BITS = 12,
    parameter int CTR_BITS   = 2,
    parameter int GHR_BITS   = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             rdy,
    output logic             busy,
    bht_gshare_if.slave      bus
);

    localparam int TABLE_SIZE = 1 << INDEX_BITS;
    // Weakly not-taken: MSB clear, all lower bits set.
    localparam logic [CTR_BITS-1:0] CTR_INIT = {1'b0, {(CTR_BITS-1){1'b1}}};
    localparam logic [CTR_BITS-1:0] CTR_MAX  = '1;

    typedef enum logic {ST_CLEAR, ST_READY} state_e;

    state_e                state_q, state_d;
    logic [INDEX_BITS-1:0] clr_ptr_q, clr_ptr_d;
    logic [GHR_BITS-1:0]   ghr_q, ghr_d;
    logic                  pred_out_valid_q, pred_out_valid_d;
    logic                  pred_taken_q, pred_taken_d;
    logic [INDEX_BITS-1:0] pred_index_q, pred_index_d;
    logic [GHR_BITS-1:0]   pred_ghr_q, pred_ghr_d;

    logic [CTR_BITS-1:0]   ctr_table_q [TABLE_SIZE];

    logic                  pred_accept;
    logic                  upd_accept;
    logic [INDEX_BITS-1:0] ghr_ext;
    logic [INDEX_BITS-1:0] pred_idx;
    logic                  pred_bit;
    logic [CTR_BITS-1:0]   upd_ctr;
    logic                  tbl_wr_en;
    logic [INDEX_BITS-1:0] tbl_wr_addr;
    logic [CTR_BITS-1:0]   tbl_wr_data;
    logic                  unused_pc_bits;

    assign unused_pc_bits = ^{bus.pred_pc[31:INDEX_BITS+2], bus.pred_pc[1:0]};

    // State register plus the registered datapath; the table itself has no reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q          <= ST_CLEAR;
            clr_ptr_q        <= '0;
            ghr_q            <= '0;
            pred_out_valid_q <= 1'b0;
            pred_taken_q     <= 1'b0;
            pred_index_q     <= '0;
            pred_ghr_q       <= '0;
        end else begin
            state_q          <= state_d;
            clr_ptr_q        <= clr_ptr_d;
            ghr_q            <= ghr_d;
            pred_out_valid_q <= pred_out_valid_d;
            pred_taken_q     <= pred_taken_d;
            pred_index_q     <= pred_index_d;
            pred_ghr_q       <= pred_ghr_d;
        end
    end

    always_ff @(posedge clk) begin
        if (tbl_wr_en) begin
            ctr_table_q[tbl_wr_addr] <= tbl_wr_data;
        end
    end

    // Next state: the clear pointer walks once through the table, then READY.
    always_comb begin
        state_d   = state_q;
        clr_ptr_d = clr_ptr_q;
        if (rdy && state_q == ST_CLEAR) begin
            clr_ptr_d = clr_ptr_q + INDEX_BITS'(1);
            if (clr_ptr_q == '1) begin
                state_d = ST_READY;
            end
        end
    end

    // Datapath: prediction, history and the single table write port.
    // The prediction reads the table before any same-cycle update lands.
    always_comb begin
        pred_accept = rdy && (state_q == ST_READY) && bus.pred_valid;
        upd_accept  = rdy && (state_q == ST_READY) && bus.upd_valid;

        ghr_ext                = '0;
        ghr_ext[GHR_BITS-1:0]  = ghr_q;
        pred_idx               = bus.pred_pc[INDEX_BITS+1:2] ^ ghr_ext;
        pred_bit               = ctr_table_q[pred_idx][CTR_BITS-1];
        upd_ctr                = ctr_table_q[bus.upd_index];

        pred_out_valid_d = pred_accept;
        pred_taken_d     = pred_taken_q;
        pred_index_d     = pred_index_q;
        pred_ghr_d       = pred_ghr_q;
        if (pred_accept) begin
            pred_taken_d = pred_bit;
            pred_index_d = pred_idx;
            pred_ghr_d   = ghr_q;
        end

        // Mispredict recovery wins over the speculative shift.
        ghr_d = ghr_q;
        if (upd_accept && bus.upd_mispredict) begin
            ghr_d = GHR_BITS'({bus.upd_ghr, bus.upd_taken});
        end else if (pred_accept) begin
            ghr_d = GHR_BITS'({ghr_q, pred_bit});
        end

        tbl_wr_en   = 1'b0;
        tbl_wr_addr = clr_ptr_q;
        tbl_wr_data = CTR_INIT;
        if (rdy && state_q == ST_CLEAR) begin
            tbl_wr_en = 1'b1;
        end else if (upd_accept) begin
            tbl_wr_en   = 1'b1;
            tbl_wr_addr = bus.upd_index;
            if (bus.upd_taken) begin
                tbl_wr_data = (upd_ctr == CTR_MAX) ? upd_ctr : upd_ctr + CTR_BITS'(1);
            end else begin
                tbl_wr_data = (upd_ctr == '0) ? upd_ctr : upd_ctr - CTR_BITS'(1);
            end
        end
    end

    // Outputs.
    always_comb begin
        busy               = (state_q == ST_CLEAR);
        bus.pred_out_valid = pred_out_valid_q;
        bus.pred_taken     = pred_taken_q;
        bus.pred_index     = pred_index_q;
        bus.pred_ghr       = pred_ghr_q;
    end

endmodule
